// File: rtl/uart_cfg_pkg.sv
// Shared codes for the UART configuration register bank: opcodes, read selects,
// response bytes and FSM states.
package uart_cfg_pkg;

   typedef enum logic [1:0] {
      OP_WR_TYPE = 2'd0,
      OP_WR_AMP  = 2'd1,
      OP_WR_FREQ = 2'd2,
      OP_READ    = 2'd3
   } opcode_t;

   localparam logic [7:0] SEL_TYPE = 8'd0;
   localparam logic [7:0] SEL_AMP  = 8'd1;
   localparam logic [7:0] SEL_FREQ = 8'd2;

   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_PL,
      ST_EXEC,
      ST_RESP
   } state_t;

   // True when an 8-bit payload is representable in a field of the given width.
   function automatic logic fits_width(input logic [7:0] value, input int unsigned width);
      return (width >= 8) || ((value >> width) == 8'd0);
   endfunction

endpackage

// File: rtl/uart_cfg_regbank_rx_strobe_gen.sv
// Rising-edge detector on the receiver's level-style data_ready: one rx_stb per byte.
module rx_strobe_gen (
   input  logic clk,
   input  logic rst,
   input  logic rx_ready,
   output logic rx_stb
);

   logic rx_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_prev <= 1'b0;
      else     rx_prev <= rx_ready;
   end

   assign rx_stb = rx_ready & ~rx_prev;

endmodule

// File: rtl/uart_cfg_regbank.sv
// Multi-channel UART config decoder: parses header+payload commands, updates
// per-channel freq/amp/wave registers, answers with ACK/NAK/read data.
module uart_cfg_regbank
   import uart_cfg_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int FREQ_W      = 7,
   parameter int AMP_W       = 4,
   parameter int TYPE_W      = 2,
   parameter int FREQ_RST    = 10,
   parameter int AMP_RST     = 7,
   parameter int TYPE_RST    = 1,
   parameter int TIMEOUT_CYC = 5000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_ready,
   input  logic [7:0]               rx_data,
   input  logic                     tx_busy,
   output logic                     tx_start,
   output logic [7:0]               tx_data,
   output logic [NUM_CH*FREQ_W-1:0] freq_o,
   output logic [NUM_CH*AMP_W-1:0]  amp_o,
   output logic [NUM_CH*TYPE_W-1:0] wave_o,
   output logic [NUM_CH-1:0]        cfg_upd_o,
   output logic                     overrun_o,
   output logic                     err_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [FREQ_W-1:0] FREQ_RST_V  = FREQ_W'(FREQ_RST);
   localparam logic [AMP_W-1:0]  AMP_RST_V   = AMP_W'(AMP_RST);
   localparam logic [TYPE_W-1:0] TYPE_RST_V  = TYPE_W'(TYPE_RST);

   logic                     rx_stb;
   state_t                   state;
   logic [CNT_W-1:0]         cnt;
   logic [7:0]               hdr_q;
   logic [7:0]               pl_q;
   logic [7:0]               resp_q;
   logic                     nak_q;
   logic [NUM_CH*FREQ_W-1:0] freq_q;
   logic [NUM_CH*AMP_W-1:0]  amp_q;
   logic [NUM_CH*TYPE_W-1:0] wave_q;

   logic [5:0] hdr_ch;
   opcode_t    hdr_op;
   logic       ch_ok;
   logic       val_ok;
   logic       cmd_ok;
   logic [7:0] rd_byte;

   rx_strobe_gen u_rx_strobe (
      .clk      (clk),
      .rst      (rst),
      .rx_ready (rx_ready),
      .rx_stb   (rx_stb)
   );

   assign hdr_ch = hdr_q[5:0];
   assign hdr_op = opcode_t'(hdr_q[7:6]);

   always_comb begin
      ch_ok = ({26'd0, hdr_ch} < 32'(NUM_CH));
      case (hdr_op)
         OP_WR_TYPE: val_ok = fits_width(pl_q, TYPE_W);
         OP_WR_AMP:  val_ok = fits_width(pl_q, AMP_W);
         OP_WR_FREQ: val_ok = fits_width(pl_q, FREQ_W);
         OP_READ:    val_ok = (pl_q <= SEL_FREQ);
      endcase
      cmd_ok = ch_ok & val_ok;

      rd_byte = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (hdr_ch == 6'(i)) begin
            case (pl_q)
               SEL_TYPE: rd_byte[TYPE_W-1:0] = wave_q[i*TYPE_W +: TYPE_W];
               SEL_AMP:  rd_byte[AMP_W-1:0]  = amp_q[i*AMP_W +: AMP_W];
               SEL_FREQ: rd_byte[FREQ_W-1:0] = freq_q[i*FREQ_W +: FREQ_W];
               default:  rd_byte = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         hdr_q     <= '0;
         pl_q      <= '0;
         resp_q    <= '0;
         nak_q     <= 1'b0;
         freq_q    <= {NUM_CH{FREQ_RST_V}};
         amp_q     <= {NUM_CH{AMP_RST_V}};
         wave_q    <= {NUM_CH{TYPE_RST_V}};
         tx_start  <= 1'b0;
         tx_data   <= '0;
         cfg_upd_o <= '0;
         overrun_o <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         tx_start  <= 1'b0;
         err_o     <= 1'b0;
         cfg_upd_o <= '0;

         case (state)
            ST_IDLE: begin
               if (rx_stb) begin
                  hdr_q <= rx_data;
                  cnt   <= '0;
                  state <= ST_WAIT_PL;
               end
            end

            // A payload arriving on the timeout cycle is still accepted.
            ST_WAIT_PL: begin
               if (rx_stb) begin
                  pl_q  <= rx_data;
                  state <= ST_EXEC;
               end else if (cnt == CNT_LAST) begin
                  resp_q <= RSP_NAK;
                  nak_q  <= 1'b1;
                  state  <= ST_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_EXEC: begin
               if (rx_stb) overrun_o <= 1'b1;
               state <= ST_RESP;
               if (!cmd_ok) begin
                  resp_q <= RSP_NAK;
                  nak_q  <= 1'b1;
               end else if (hdr_op == OP_READ) begin
                  resp_q <= rd_byte;
                  nak_q  <= 1'b0;
               end else begin
                  resp_q <= RSP_ACK;
                  nak_q  <= 1'b0;
                  for (int unsigned i = 0; i < NUM_CH; i++) begin
                     if (hdr_ch == 6'(i)) begin
                        cfg_upd_o[i] <= 1'b1;
                        case (hdr_op)
                           OP_WR_TYPE: wave_q[i*TYPE_W +: TYPE_W] <= pl_q[TYPE_W-1:0];
                           OP_WR_AMP:  amp_q[i*AMP_W +: AMP_W]    <= pl_q[AMP_W-1:0];
                           OP_WR_FREQ: freq_q[i*FREQ_W +: FREQ_W] <= pl_q[FREQ_W-1:0];
                           OP_READ:    ;
                        endcase
                     end
                  end
               end
            end

            ST_RESP: begin
               if (rx_stb) overrun_o <= 1'b1;
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  tx_data  <= resp_q;
                  err_o    <= nak_q;
                  state    <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign freq_o = freq_q;
   assign amp_o  = amp_q;
   assign wave_o = wave_q;

endmodule

// File: tb/tb_uart_cfg_regbank.sv
// Scoreboard bench for uart_cfg_regbank: expected responses queued at stimulus,
// popped when tx_start fires; register outputs checked against a channel model.
module tb_uart_cfg_regbank;

   localparam int NCH = 2;
   localparam int TO  = 100;

   typedef struct {
      logic [7:0] b;
      logic       nak;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               rx_ready;
   logic [7:0]         rx_data;
   logic               tx_busy;
   logic               tx_start;
   logic [7:0]         tx_data;
   logic [NCH*7-1:0]   freq_o;
   logic [NCH*4-1:0]   amp_o;
   logic [NCH*2-1:0]   wave_o;
   logic [NCH-1:0]     cfg_upd_o;
   logic               overrun_o;
   logic               err_o;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_tx     = 0;

   logic [6:0] m_freq[NCH];
   logic [3:0] m_amp[NCH];
   logic [1:0] m_wave[NCH];

   uart_cfg_regbank #(
      .NUM_CH      (NCH),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .freq_o    (freq_o),
      .amp_o     (amp_o),
      .wave_o    (wave_o),
      .cfg_upd_o (cfg_upd_o),
      .overrun_o (overrun_o),
      .err_o     (err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && tx_start) begin
         n_tx++;
         if (exp_q.size() == 0) begin
            check("tx_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e.b));
            check("err_o", 32'(err_o), 32'(e.nak));
         end
      end else if (!rst && err_o) begin
         check("err_spurious", 32'd1, 32'd0);
      end
   end

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_freq[i] = 7'd10;
         m_amp[i]  = 4'd7;
         m_wave[i] = 2'd1;
      end
   endtask

   task automatic check_regs(input string tag);
      logic [NCH*7-1:0] ef;
      logic [NCH*4-1:0] ea;
      logic [NCH*2-1:0] ew;
      for (int i = 0; i < NCH; i++) begin
         ef[i*7 +: 7] = m_freq[i];
         ea[i*4 +: 4] = m_amp[i];
         ew[i*2 +: 2] = m_wave[i];
      end
      check({tag, "_freq"}, 32'(freq_o), 32'(ef));
      check({tag, "_amp"},  32'(amp_o),  32'(ea));
      check({tag, "_wave"}, 32'(wave_o), 32'(ew));
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one byte for one cycle; returns 1 time unit after the strobe's edge.
   task automatic pulse_byte(input logic [7:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
   endtask

   task automatic wait_resp(input string tag);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
      check({tag, "_resp_wait"}, 32'(exp_q.size()), 32'd0);
      tick(1);
   endtask

   // Predicts the response and register effect, pushes the expectation, then
   // sends the command and checks the write timing (regs/cfg_upd at N+2).
   task automatic do_cmd(input string tag, input logic [7:0] hdr, input logic [7:0] pl);
      exp_t           e;
      int             ch;
      int             op;
      logic [NCH-1:0] mask;
      logic           ok;
      ch   = int'(hdr[5:0]);
      op   = int'(hdr[7:6]);
      mask = '0;
      case (op)
         0:       ok = (pl < 8'd4);
         1:       ok = (pl < 8'd16);
         2:       ok = (pl < 8'd128);
         default: ok = (pl <= 8'd2);
      endcase
      if (ch >= NCH) ok = 1'b0;
      e.nak = ~ok;
      e.b   = ok ? 8'h06 : 8'h15;
      if (ok) begin
         case (op)
            0: begin m_wave[ch] = pl[1:0]; mask[ch] = 1'b1; end
            1: begin m_amp[ch]  = pl[3:0]; mask[ch] = 1'b1; end
            2: begin m_freq[ch] = pl[6:0]; mask[ch] = 1'b1; end
            default: e.b = (pl == 8'd0) ? 8'(m_wave[ch]) :
                           (pl == 8'd1) ? 8'(m_amp[ch]) : 8'(m_freq[ch]);
         endcase
      end
      exp_q.push_back(e);
      pulse_byte(hdr);
      tick(1);
      pulse_byte(pl);
      check({tag, "_upd_n1"}, 32'(cfg_upd_o), 32'd0);
      tick(1);
      check({tag, "_upd_n2"}, 32'(cfg_upd_o), 32'(mask));
      check_regs(tag);
      wait_resp(tag);
      check({tag, "_upd_after"}, 32'(cfg_upd_o), 32'd0);
   endtask

   initial begin
      exp_t e;
      int   tx_before;
      rst      = 1'b1;
      rx_ready = 1'b0;
      rx_data  = '0;
      tx_busy  = 1'b0;
      model_reset();
      tick(3);
      rst = 1'b0;

      // Reset state, idle bus
      tick(20);
      check_regs("reset");
      check("reset_tx_count", 32'(n_tx), 32'd0);
      check("reset_overrun", 32'(overrun_o), 32'd0);
      check("reset_tx_data", 32'(tx_data), 32'd0);

      // Writes
      do_cmd("wr_freq_ch1", 8'h81, 8'h2A);
      do_cmd("wr_type_ch0", 8'h00, 8'h03);
      do_cmd("wr_freq_max", 8'h80, 8'h7F);

      // Invalid commands
      do_cmd("nak_chan", 8'h45, 8'h03);
      do_cmd("nak_amp", 8'h40, 8'h10);
      do_cmd("nak_freq", 8'h81, 8'h80);
      do_cmd("nak_type", 8'h01, 8'h04);

      // Read-back
      do_cmd("wr_amp_ch0", 8'h40, 8'h09);
      do_cmd("rd_amp_ch0", 8'hC0, 8'h01);
      do_cmd("rd_freq_ch1", 8'hC1, 8'h02);
      do_cmd("rd_type_ch0", 8'hC0, 8'h00);
      do_cmd("nak_rd_sel", 8'hC0, 8'h03);
      do_cmd("nak_rd_chan", 8'hC2, 8'h00);

      // Header with no payload: timeout NAK, then normal operation resumes
      e.b = 8'h15; e.nak = 1'b1;
      exp_q.push_back(e);
      pulse_byte(8'h80);
      wait_resp("timeout");
      do_cmd("after_timeout", 8'h80, 8'h11);

      // Transmitter busy during RESP plus an extra byte -> overrun, delayed tx_start
      check("pre_overrun", 32'(overrun_o), 32'd0);
      tx_busy   = 1'b1;
      tx_before = n_tx;
      e.b = 8'h06; e.nak = 1'b0;
      exp_q.push_back(e);
      m_freq[0] = 7'd5;
      pulse_byte(8'h80);
      tick(1);
      pulse_byte(8'h05);
      tick(1);
      pulse_byte(8'h55);
      tick(1);
      check("overrun_set", 32'(overrun_o), 32'd1);
      tick(10);
      check("busy_no_tx", 32'(n_tx), 32'(tx_before));
      check_regs("busy");
      tx_busy = 1'b0;
      wait_resp("busy");
      check("overrun_sticky", 32'(overrun_o), 32'd1);

      // Level held high for 20 cycles is a single header strobe
      e.b = 8'h06; e.nak = 1'b0;
      exp_q.push_back(e);
      m_amp[1]  = 4'd3;
      rx_data  = 8'h41;
      rx_ready = 1'b1;
      tick(20);
      rx_ready = 1'b0;
      tick(1);
      pulse_byte(8'h03);
      wait_resp("hold_level");
      check_regs("hold_level");

      // Reset while waiting for a payload aborts with no change
      pulse_byte(8'h81);
      tick(2);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      model_reset();
      tx_before = n_tx;
      tick(TO + 20);
      check_regs("rst_wait_pl");
      check("rst_overrun", 32'(overrun_o), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_no_tx", 32'(n_tx), 32'(tx_before));
      do_cmd("after_rst", 8'h81, 8'h33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
